seg7_decoder: RTL
=================

SEG7_DECODER -- requirements
Module: seg7_decoder

Interface
REQ-001 Parameter ACC_W, default 8: accumulator width in bits (legal 7..16).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-low.
REQ-004 in_valid  input  1  segment pair on seg_tens/seg_ones is valid.
REQ-005 in_ready  output  1  block can accept a segment pair.
REQ-006 seg_ones  input  7  active-low pattern of the units digit, bit6=a .. bit0=g.
REQ-007 seg_tens  input  7  active-low pattern of the tens digit, same bit order.
REQ-008 out_valid  output  1  decoded result valid.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 bcd_ones  output  4  decoded units digit.
REQ-011 bcd_tens  output  4  decoded tens digit.
REQ-012 bin_value  output  7  tens*10+ones, range 0..99.
REQ-013 err  output  1  result invalid; qualified by out_valid.
REQ-014 acc_clr  input  1  clears the accumulator.
REQ-015 acc  output  ACC_W  running sum of accepted valid results.

Function
REQ-016 The decode table SHALL be: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-017 Any pattern not in the table SHALL be illegal; blank (1111111) SHALL be handled per REQ-031.
REQ-018 FSM states SHALL be IDLE, DECODE, CONVERT and HOLD.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 A transfer in IDLE with in_valid=1 SHALL capture both patterns into registers and go to DECODE.
REQ-021 DECODE SHALL take one cycle: register both digits and the illegal flags, then go to CONVERT.
REQ-022 CONVERT SHALL take one cycle: compute bin_value = (tens<<3)+(tens<<1)+ones, register it and err, then go to HOLD.
REQ-023 out_valid SHALL be 1 only in HOLD, first asserted 3 cycles after the accepting edge.
REQ-024 While out_valid=1 and out_ready=0, all outputs SHALL hold stable.
REQ-025 out_valid=1 with out_ready=1 SHALL complete the transfer and return to IDLE; maximum throughput is one pair per 4 cycles.
REQ-026 If either digit is illegal: err=1, bin_value=0, bcd_ones=0, bcd_tens=0.
REQ-027 On a completed transfer with err=0, acc SHALL become acc+bin_value, wrapping modulo 2^ACC_W; with err=1, acc SHALL be unchanged.
REQ-028 acc_clr=1 SHALL set acc to 0 in any state; if a valid transfer completes in the same cycle, acc SHALL become bin_value.

Reset
REQ-029 When reset=0 at a clock edge: state=IDLE, out_valid=0, in_ready=1 in the following cycle, and err, bin_value, bcd_ones, bcd_tens and acc all 0.
REQ-030 Reset mid-operation (DECODE, CONVERT or HOLD) SHALL discard the pending pair with no acc update.

Configuration
REQ-031 With SEG7_DEC_BLANK_EN defined, a blank seg_tens SHALL decode as 0 (leading-zero blanking); without it, a blank seg_tens SHALL be illegal; a blank seg_ones SHALL always be illegal.

Structure
REQ-032 Package seg7_pkg SHALL hold the ten digit-pattern constants, SEG_BLANK and the FSM state typedef.
REQ-033 Sub-module seg7_digit_dec SHALL be combinational (pattern in; digit and legal flag out), instantiated twice, with a blank_ok input.

Verification
REQ-034 Reset held 2 cycles, then released -> out_valid=0, in_ready=1, acc=0, bin_value=0.
REQ-035 tens=0010010, ones=0100100, out_ready=1 -> out_valid on the 3rd cycle after acceptance with bcd_tens=2, bcd_ones=5, bin_value=25, err=0; then acc=25.
REQ-036 Same pair again with out_ready=0 for 5 cycles -> outputs stable and in_ready=0; after out_ready=1, acc=50.
REQ-037 ones=0110110 -> err=1, bin_value=0, acc unchanged.
REQ-038 tens=1111111, ones=0001111 -> bin_value=7 with the macro defined; err=1 without it.
REQ-039 acc=250 plus 25 -> acc=19 (ACC_W=8); acc_clr coincident with a valid transfer of 25 -> acc=25; reset asserted in CONVERT -> IDLE, out_valid=0, acc=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment pair decoder:
//   - active-low segment patterns for digits 0..9 (bit6=a .. bit0=g)
//   - SEG_BLANK, the all-segments-off pattern
//   - seg7_state_t, the decoder FSM state encoding
// ----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DECODE  = 2'd1,
        CONVERT = 2'd2,
        HOLD    = 2'd3
    } seg7_state_t;

endpackage

// File: rtl/seg7_digit_dec.sv
// ----------------------------------------------------------------------------
// seg7_digit_dec
// Purely combinational decode of one active-low seven-segment pattern.
// Ports:
//   pattern  [6:0] in   active-low segments, bit6=a .. bit0=g
//   blank_ok       in   1: the blank pattern is accepted and reads as 0
//   digit    [3:0] out  decoded value (0 when the pattern is illegal)
//   legal          out  1 when the pattern is a recognised digit
// ----------------------------------------------------------------------------
module seg7_digit_dec
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    input  logic       blank_ok,
    output logic [3:0] digit,
    output logic       legal
);

    always_comb begin
        digit = 4'd0;
        legal = 1'b1;
        case (pattern)
            SEG_0:     digit = 4'd0;
            SEG_1:     digit = 4'd1;
            SEG_2:     digit = 4'd2;
            SEG_3:     digit = 4'd3;
            SEG_4:     digit = 4'd4;
            SEG_5:     digit = 4'd5;
            SEG_6:     digit = 4'd6;
            SEG_7:     digit = 4'd7;
            SEG_8:     digit = 4'd8;
            SEG_9:     digit = 4'd9;
            // Blank reads as a leading zero only where the caller allows it.
            SEG_BLANK: legal = blank_ok;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_decoder.sv
// ----------------------------------------------------------------------------
// seg7_decoder
// Accepts a pair of active-low seven-segment digit patterns (tens, ones),
// decodes them to BCD and to a binary value 0..99, and keeps a running sum
// of the legal results. Four-state pipeline FSM: IDLE -> DECODE -> CONVERT
// -> HOLD, so at most one pair per four cycles.
//
// Build option: define SEG7_DEC_BLANK_EN to let a blank tens digit decode as
// 0 (leading-zero blanking). Without it a blank tens digit is illegal. A
// blank ones digit is always illegal.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low
//   in_valid   in   seg_tens/seg_ones hold a pair
//   in_ready   out  block accepts a pair (IDLE only)
//   seg_ones   in   [6:0] units pattern, active-low, bit6=a .. bit0=g
//   seg_tens   in   [6:0] tens pattern, same encoding
//   out_valid  out  result valid (HOLD only)
//   out_ready  in   consumer takes the result
//   bcd_ones   out  [3:0] units digit
//   bcd_tens   out  [3:0] tens digit
//   bin_value  out  [6:0] tens*10+ones
//   err        out  either digit illegal; result fields forced to 0
//   acc_clr    in   clear the accumulator
//   acc        out  [ACC_W-1:0] running sum of accepted legal results
// ----------------------------------------------------------------------------
module seg7_decoder
    import seg7_pkg::*;
#(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       seg_ones,
    input  logic [6:0]       seg_tens,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       bcd_ones,
    output logic [3:0]       bcd_tens,
    output logic [6:0]       bin_value,
    output logic             err,
    input  logic             acc_clr,
    output logic [ACC_W-1:0] acc
);

`ifdef SEG7_DEC_BLANK_EN
    localparam logic BLANK_TENS_OK = 1'b1;
`else
    localparam logic BLANK_TENS_OK = 1'b0;
`endif

    // Index 0 = ones digit, index 1 = tens digit.
    localparam int NUM_DIGITS = 2;

    seg7_state_t       state_reg;
    logic [6:0]        pat_reg   [NUM_DIGITS];
    logic [3:0]        dig_reg   [NUM_DIGITS];
    logic              ill_reg   [NUM_DIGITS];
    logic [3:0]        dig_w     [NUM_DIGITS];
    logic              legal_w   [NUM_DIGITS];
    logic [3:0]        bcd_ones_reg;
    logic [3:0]        bcd_tens_reg;
    logic [6:0]        bin_reg;
    logic              err_reg;
    logic              out_valid_reg;
    logic              in_ready_reg;
    logic [ACC_W-1:0]  acc_reg;

    logic [6:0]        tens_w7;
    logic [6:0]        ones_w7;
    logic [6:0]        bin_next;
    logic              err_next;
    logic              done;
    logic [ACC_W-1:0]  bin_ext;

    // Decoders operate on the captured patterns, so the input bus is free
    // as soon as the pair has been accepted.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
            seg7_digit_dec u_dec (
                .pattern  (pat_reg[gi]),
                .blank_ok ((gi == 1) ? BLANK_TENS_OK : 1'b0),
                .digit    (dig_w[gi]),
                .legal    (legal_w[gi])
            );
        end
    endgenerate

    // tens*10 as shift-and-add; 9*10+9 = 99 fits in 7 bits.
    assign tens_w7  = {3'b000, dig_reg[1]};
    assign ones_w7  = {3'b000, dig_reg[0]};
    assign err_next = ill_reg[0] | ill_reg[1];
    assign bin_next = err_next ? 7'd0 : ((tens_w7 << 3) + (tens_w7 << 1) + ones_w7);

    assign done    = (state_reg == HOLD) && out_ready;
    assign bin_ext = ACC_W'(bin_reg);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            bcd_ones_reg  <= 4'd0;
            bcd_tens_reg  <= 4'd0;
            bin_reg       <= 7'd0;
            err_reg       <= 1'b0;
            acc_reg       <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                pat_reg[i] <= SEG_BLANK;
                dig_reg[i] <= 4'd0;
                ill_reg[i] <= 1'b0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        pat_reg[0]   <= seg_ones;
                        pat_reg[1]   <= seg_tens;
                        in_ready_reg <= 1'b0;
                        state_reg    <= DECODE;
                    end
                end
                DECODE: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        dig_reg[i] <= dig_w[i];
                        ill_reg[i] <= ~legal_w[i];
                    end
                    state_reg <= CONVERT;
                end
                CONVERT: begin
                    bin_reg       <= bin_next;
                    err_reg       <= err_next;
                    bcd_ones_reg  <= err_next ? 4'd0 : dig_reg[0];
                    bcd_tens_reg  <= err_next ? 4'd0 : dig_reg[1];
                    out_valid_reg <= 1'b1;
                    state_reg     <= HOLD;
                end
                HOLD: begin
                    // Result registers are left untouched until the next
                    // CONVERT, so they stay stable through any stall.
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    state_reg     <= IDLE;
                end
            endcase

            // A clear coincident with a legal completion loads the new
            // result rather than discarding it.
            if (acc_clr) begin
                acc_reg <= (done && !err_reg) ? bin_ext : '0;
            end else if (done && !err_reg) begin
                acc_reg <= acc_reg + bin_ext;
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign bcd_ones  = bcd_ones_reg;
    assign bcd_tens  = bcd_tens_reg;
    assign bin_value = bin_reg;
    assign err       = err_reg;
    assign acc       = acc_reg;

endmodule
